pwm_scan_ctrl: RTL and testbench

- AXI4-Lite master that sequences threshold scans on the 24-channel PWM threshold core.
- On start, it writes a duty value to every enabled channel's duty register, holds for a dwell time, then adds a step and repeats for N steps.
- Sits beside the Wishbone-to-AXI adapter, muxed onto the PWM core's AXI slave port by the wrapper. Software configures a scan and then only polls status.

---
 rtl/pwm_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pwm_scan_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_scan_ctrl.sv
// pwm_scan_ctrl: AXI4-Lite write master that steps a duty value across every
// enabled PWM channel, holding each step for a programmable dwell time.
module pwm_scan_ctrl #(
  parameter int unsigned NCH     = 24,
  parameter int unsigned DUTY_W  = 16,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DUTY_W-1:0]  cfg_start_i,
  input  logic [DUTY_W-1:0]  cfg_step_i,
  input  logic [15:0]        cfg_nsteps_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic [NCH-1:0]     cfg_mask_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic               err_o,
  output logic               step_o,
  output logic [DUTY_W-1:0]  cur_value_o,
  output logic [15:0]        step_idx_o,
  output logic [8:0]         m_axi_awaddr,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [31:0]        m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready
);
  localparam int unsigned CH_W = $clog2(NCH);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_WADDR, S_WRESP, S_DWELL, S_FIN
  } state_t;

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cfg;
  logic [DUTY_W-1:0]  step_cfg;
  logic [15:0]        nsteps;
  logic [NCH-1:0]     mask;
  logic               abort_pend;

  logic [DUTY_W:0]    sum_c;
  logic [15:0]        idx_next_c;
  logic               abort_c;
  logic               last_ch_c;

  assign sum_c      = {1'b0, cur_value_o} + {1'b0, step_cfg};
  assign idx_next_c = step_idx_o + 16'd1;
  assign abort_c    = abort_i | abort_pend;
  assign last_ch_c  = (ch == CH_W'(NCH - 1));

  // Scan sequencer; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      ch            <= '0;
      dwell_cnt     <= '0;
      dwell_cfg     <= '0;
      step_cfg      <= '0;
      nsteps        <= '0;
      mask          <= '0;
      abort_pend    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      aborted_o     <= 1'b0;
      err_o         <= 1'b0;
      step_o        <= 1'b0;
      cur_value_o   <= '0;
      step_idx_o    <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      step_o <= 1'b0;
      // An abort seen mid-write is remembered until the next SEEK/DWELL.
      if (busy_o && abort_i) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            step_cfg    <= cfg_step_i;
            nsteps      <= cfg_nsteps_i;
            dwell_cfg   <= cfg_dwell_i;
            mask        <= cfg_mask_i;
            aborted_o   <= 1'b0;
            err_o       <= 1'b0;
            abort_pend  <= 1'b0;
            cur_value_o <= cfg_start_i;
            step_idx_o  <= '0;
            ch          <= '0;
            busy_o      <= 1'b1;
            if (cfg_nsteps_i == 16'd0) begin
              state  <= S_FIN;
              done_o <= 1'b1;
            end else begin
              state <= S_SEEK;
            end
          end
        end

        S_SEEK: begin
          if (abort_c) begin
            aborted_o <= 1'b1;
            done_o    <= 1'b1;
            state     <= S_FIN;
          end else if (mask[ch]) begin
            m_axi_awaddr  <= 9'({ch, 2'b00});
            m_axi_wdata   <= 32'(cur_value_o);
            m_axi_wstrb   <= 4'hF;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= S_WADDR;
          end else if (last_ch_c) begin
            step_o    <= 1'b1;
            dwell_cnt <= dwell_cfg;
            state     <= S_DWELL;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end

        S_WADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) err_o <= 1'b1;
            if (last_ch_c) begin
              step_o    <= 1'b1;
              dwell_cnt <= dwell_cfg;
              state     <= S_DWELL;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= S_SEEK;
            end
          end
        end

        S_DWELL: begin
          if (abort_c) begin
            aborted_o <= 1'b1;
            done_o    <= 1'b1;
            state     <= S_FIN;
          end else if (dwell_cnt == '0) begin
            step_idx_o <= idx_next_c;
            if (idx_next_c == nsteps) begin
              done_o <= 1'b1;
              state  <= S_FIN;
            end else begin
              // Saturate instead of wrapping past full scale.
              cur_value_o <= sum_c[DUTY_W] ? {DUTY_W{1'b1}} : sum_c[DUTY_W-1:0];
              ch          <= '0;
              state       <= S_SEEK;
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        S_FIN: begin
          busy_o     <= 1'b0;
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// tb_pwm_scan_ctrl: directed and randomized scans checked against a
// transaction-level model of the write stream, step pulses and status flags.
module tb_pwm_scan_ctrl;
  localparam int unsigned NCH     = 24;
  localparam int unsigned DUTY_W  = 16;
  localparam int unsigned DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [DUTY_W-1:0]  cfg_start = '0;
  logic [DUTY_W-1:0]  cfg_step = '0;
  logic [15:0]        cfg_nsteps = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [NCH-1:0]     cfg_mask = '0;
  logic               busy, done, aborted, err, step;
  logic [DUTY_W-1:0]  cur_value;
  logic [15:0]        step_idx;
  logic [8:0]         awaddr;
  logic               awvalid;
  logic               awready = 1'b0;
  logic [31:0]        wdata;
  logic [3:0]         wstrb;
  logic               wvalid;
  logic               wready = 1'b0;
  logic [1:0]         bresp = 2'b00;
  logic               bvalid = 1'b0;
  logic               bready;

  pwm_scan_ctrl #(.NCH(NCH), .DUTY_W(DUTY_W), .DWELL_W(DWELL_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .cfg_start_i(cfg_start), .cfg_step_i(cfg_step), .cfg_nsteps_i(cfg_nsteps),
    .cfg_dwell_i(cfg_dwell), .cfg_mask_i(cfg_mask),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_o(err), .step_o(step),
    .cur_value_o(cur_value), .step_idx_o(step_idx),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of one scan, built from the configuration before start.
  int vals[$];
  int exp_addr[$];
  int exp_data[$];
  int m_dwell, err_at, exp_final_idx, exp_final_val;
  bit stall_rnd, abort_req, exp_abort, mon_en;

  // Monitor/slave state.
  int  aw_cnt, w_cnt, b_cnt, step_seen, done_cnt, cyc, last_step_cyc;
  int  aw_wait, w_wait, b_wait;
  bit  exp_busy, exp_err, chk_done_next, b_fire, abort_done, gap_pending;
  logic       prev_awv, prev_awh, prev_wv, prev_wh;
  logic [8:0] prev_awaddr, last_aw_addr;
  logic [31:0] prev_wdata, lookup;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void build_model(int st, int sp, int n, logic [NCH-1:0] mk);
    int v = st;
    vals.delete(); exp_addr.delete(); exp_data.delete();
    for (int s = 0; s < n; s++) begin
      vals.push_back(v);
      for (int c = 0; c < NCH; c++)
        if (mk[c]) begin
          exp_addr.push_back(4 * c);
          exp_data.push_back(v);
        end
      v = (v + sp > 65535) ? 65535 : v + sp;
    end
  endfunction

  // Per-cycle compare process plus AXI slave; samples on the falling edge.
  initial begin
    cyc = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    exp_busy = 0; exp_err = 0; b_fire = 0; chk_done_next = 0;
    prev_awv = 0; prev_awh = 0; prev_wv = 0; prev_wh = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        awready = 0; wready = 0; bvalid = 0; abort = 0;
        prev_awv = 0; prev_wv = 0; b_fire = 0; exp_busy = 0; exp_err = 0;
        continue;
      end
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      abort = 0;

      chk("busy", busy, exp_busy);
      chk("err", err, exp_err);
      if (wvalid) chk("wstrb", wstrb, 4'hF);
      if (prev_awv && !prev_awh) begin
        chk("aw_held", awvalid, 1'b1);
        chk("aw_stable", awaddr, prev_awaddr);
      end
      if (prev_wv && !prev_wh) begin
        chk("w_held", wvalid, 1'b1);
        chk("w_stable", wdata, prev_wdata);
      end
      if (chk_done_next) begin
        chk("done_next_cycle", done, 1'b1);
        chk_done_next = 0;
      end

      if (!exp_busy) begin
        chk("idle_quiet", {awvalid, wvalid, bready, step, done}, 5'b0);
      end else begin
        if (!done) chk("aborted_clear", aborted, 1'b0);
        if (step) begin
          lookup = (step_seen < vals.size()) ? 32'(vals[step_seen]) : 32'hFFFF_FFFF;
          chk("step_value", cur_value, lookup);
          chk("step_index", step_idx, 32'(step_seen));
          step_seen++;
          last_step_cyc = cyc;
          gap_pending = 1;
        end
        if (awvalid && gap_pending) begin
          chk("dwell_before_write", 32'(cyc - last_step_cyc > m_dwell), 1);
          gap_pending = 0;
        end
        if (done) begin
          done_cnt++;
          chk("done_step_idx", step_idx, 32'(exp_final_idx));
          chk("done_value", cur_value, 32'(exp_final_val));
          chk("done_aborted", aborted, exp_abort);
          if (gap_pending && !exp_abort)
            chk("dwell_before_done", 32'(cyc - last_step_cyc > m_dwell), 1);
          gap_pending = 0;
        end
      end

      // Write response channel: one response per accepted AW+W pair.
      if (!bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
        if (b_wait > 0) b_wait--;
        else begin
          bvalid = 1;
          bresp  = (b_cnt + 1 == err_at) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) begin
        b_fire = 1;
        b_cnt++;
        b_wait = stall_rnd ? $urandom_range(0, 3) : 0;
      end

      if (stall_rnd) begin
        if (awvalid && aw_wait > 0) begin awready = 0; aw_wait--; end
        else awready = awvalid;
        if (wvalid && w_wait > 0) begin wready = 0; w_wait--; end
        else wready = wvalid;
      end else begin
        awready = 1; wready = 1;
      end

      prev_awv = awvalid; prev_awh = awvalid && awready; prev_awaddr = awaddr;
      prev_wv  = wvalid;  prev_wh  = wvalid && wready;   prev_wdata  = wdata;
      if (prev_awh) begin
        chk("single_outstanding", 32'(aw_cnt - b_cnt), 0);
        lookup = (aw_cnt < exp_addr.size()) ? 32'(exp_addr[aw_cnt]) : 32'hFFFF_FFFF;
        chk("aw_addr", awaddr, lookup);
        last_aw_addr = awaddr;
        aw_cnt++;
        aw_wait = stall_rnd ? $urandom_range(0, 5) : 0;
      end
      if (prev_wh) begin
        lookup = (w_cnt < exp_data.size()) ? 32'(exp_data[w_cnt]) : 32'hFFFF_FFFF;
        chk("w_data", wdata, lookup);
        w_cnt++;
        w_wait = stall_rnd ? $urandom_range(0, 5) : 0;
      end

      if (abort_req && !abort_done && bready && last_aw_addr == 9'h014 && step_seen == 1) begin
        abort = 1;
        abort_done = 1;
      end

      // Expectations for the next sample.
      if (start && !exp_busy) begin
        exp_busy = 1; exp_err = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; step_seen = 0; done_cnt = 0;
        abort_done = 0; gap_pending = 0;
        chk_done_next = (cfg_nsteps == 16'd0);
      end else if (done) begin
        exp_busy = 0;
      end
      if (b_fire && bresp != 2'b00) exp_err = 1;
    end
  end

  task automatic run_scan(input int st, input int sp, input int n, input int dw,
                          input logic [NCH-1:0] mk, input bit stall, input int ea,
                          input bit ab, input bit poke);
    int nw, budget;
    build_model(st, sp, n, mk);
    m_dwell = dw; stall_rnd = stall; err_at = ea; abort_req = ab; exp_abort = ab;
    nw = ab ? 30 : exp_addr.size();
    exp_final_idx = ab ? 1 : n;
    exp_final_val = (n == 0) ? st : (ab ? vals[1] : vals[n-1]);
    cfg_start = DUTY_W'(st); cfg_step = DUTY_W'(sp); cfg_nsteps = 16'(n);
    cfg_dwell = DWELL_W'(dw); cfg_mask = mk;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      cfg_start = 16'hABCD; cfg_step = 16'h0001; cfg_nsteps = 16'd7;
      cfg_dwell = 24'd1; cfg_mask = 24'h0F0F0F;
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    budget = 20000;
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt), 1);
    chk("aw_count", 32'(aw_cnt), 32'(nw));
    chk("w_count", 32'(w_cnt), 32'(nw));
    chk("b_count", 32'(b_cnt), 32'(nw));
    chk("step_pulses", 32'(step_seen), 32'(ab ? 1 : n));
    chk("final_err", err, (ea != 0 && ea <= nw));
    chk("final_aborted", aborted, ab);
    chk("final_busy", busy, 1'b0);
    if (budget == 0) begin
      mon_en = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      mon_en = 1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int wcnt;
    mon_en = 0; abort_req = 0; stall_rnd = 0; m_dwell = 0; err_at = 0; exp_abort = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {busy, done, aborted, err, step}, 5'b0);
    chk("rst_axi", {awvalid, wvalid, bready, wstrb}, 7'b0);
    chk("rst_value", cur_value, 0);
    chk("rst_idx", step_idx, 0);
    rst_n = 1;
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1;

    // Full mask, always-ready slave; a start pulse mid-scan must be ignored.
    run_scan(32'h1000, 32'h0100, 3, 10, 24'hFFFFFF, 0, 0, 0, 1);
    chk("t1_writes", 32'(aw_cnt), 72);
    chk("t1_model_last", 32'(exp_data[71]), 32'h1200);
    chk("t1_model_addr", 32'(exp_addr[23]), 32'h05C);
    chk("t1_value", cur_value, 16'h1200);
    chk("t1_idx", step_idx, 16'd3);

    // Sparse mask with random ready stalls.
    run_scan(32'h0042, 32'h0001, 1, 2, 24'h000005, 1, 0, 0, 0);
    chk("t2_writes", 32'(aw_cnt), 2);
    chk("t2_last_addr", last_aw_addr, 9'h008);

    // Saturation.
    run_scan(32'hFF00, 32'h0080, 4, 2, 24'h000011, 1, 0, 0, 0);
    chk("t3_model_v1", 32'(vals[1]), 32'hFF80);
    chk("t3_model_v2", 32'(vals[2]), 32'hFFFF);
    chk("t3_model_v3", 32'(vals[3]), 32'hFFFF);
    chk("t3_value", cur_value, 16'hFFFF);

    // Abort during the ch=5 response of step 1.
    run_scan(32'h2000, 32'h0010, 3, 4, 24'hFFFFFF, 0, 0, 1, 0);
    chk("t4_last_addr", last_aw_addr, 9'h014);
    chk("t4_value", cur_value, 16'h2010);

    // Error response on the third write is sticky through the scan.
    run_scan(32'h0300, 32'h0001, 2, 3, 24'h0000FF, 0, 3, 0, 0);
    chk("t5_err_sticky", err, 1'b1);

    // Zero steps: no AXI traffic, done right after start; clears the error.
    run_scan(32'h1234, 32'h0001, 0, 5, 24'hFFFFFF, 0, 0, 0, 0);
    chk("t6_err_cleared", err, 1'b0);
    chk("t6_value", cur_value, 16'h1234);

    // Empty mask: dwell-only steps.
    run_scan(32'h0010, 32'h0010, 2, 1, 24'h000000, 0, 0, 0, 0);

    // Random scans.
    for (int k = 0; k < 8; k++) begin
      logic [NCH-1:0] mk;
      mk = NCH'($urandom & $urandom);
      if (k == 3) mk = '0;
      run_scan(int'($urandom_range(0, 65535)), int'($urandom_range(0, 20000)),
               int'($urandom_range(1, 4)), int'($urandom_range(0, 5)), mk,
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0);
    end

    // Asynchronous reset while a write address is pending.
    mon_en = 0;
    cfg_start = 16'h0077; cfg_step = 16'h0001; cfg_nsteps = 16'd1;
    cfg_dwell = 24'd0; cfg_mask = 24'h000002;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wcnt = 0;
    while (!awvalid && wcnt < 100) begin
      @(posedge clk); #1;
      wcnt++;
    end
    chk("mid_rst_pending", awvalid, 1'b1);
    rst_n = 0;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, bready}, 3'b0);
    chk("mid_rst_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
